// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU op encodings, IEEE754 single field positions and constants
package fpu_pkg;

  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_SUB  = 2'd3;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  localparam logic [31:0] PZERO = 32'h0000_0000;
  localparam logic [31:0] NZERO = 32'h8000_0000;
  localparam logic [31:0] PINF  = 32'h7F80_0000;
  localparam logic [31:0] NINF  = 32'hFF80_0000;
  localparam logic [31:0] QNAN  = 32'h7FFF_FFFF;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// rtl/fpu_cmd_fifo.sv - in-order command FIFO, registered occupancy, no fall-through or bypass
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 70
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// rtl/fpu_cmd_sequencer.sv - queues FPU commands, drives go/done handshake, returns tagged results with timeout recovery
module fpu_cmd_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_d,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  output logic             fpu_go,
  output logic             fpu_reset,
  input  logic [31:0]      fpu_d,
  input  logic             fpu_done
);

  localparam int EW = 66 + TAG_W;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, HOLD} state_t;

  state_t         state, state_n;
  logic [EW-1:0]  head;
  logic           fifo_full, fifo_empty;
  logic           pop, capture, abort, timer_run;
  logic [TW-1:0]  timer;
  logic [TAG_W-1:0] tag_r;

  assign cmd_ready = !fifo_full;
  assign fpu_go    = (state == ISSUE);
  assign res_valid = (state == HOLD);
  assign res_tag   = tag_r;
  assign busy      = (state != IDLE) || !fifo_empty;

  fpu_cmd_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ARM only moves on once done is seen low, so a done left over from the
  // previous operation can never be mistaken for this one's completion.
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    timer_run = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = ARM;
      ARM: begin
        timer_run = 1'b1;
        if (timer == TMAX) begin
          abort   = 1'b1;
          state_n = HOLD;
        end else if (!fpu_done) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        timer_run = 1'b1;
        if (fpu_done) begin
          capture = 1'b1;
          state_n = HOLD;
        end else if (timer == TMAX) begin
          abort   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      tag_r     <= '0;
      timer     <= '0;
      res_d     <= '0;
      res_err   <= 1'b0;
      fpu_reset <= 1'b1;
    end else begin
      state     <= state_n;
      fpu_reset <= abort;
      if (pop) begin
        fpu_op <= head[EW-1 -: 2];
        fpu_a  <= head[EW-3 -: 32];
        fpu_b  <= head[TAG_W+31 -: 32];
        tag_r  <= head[TAG_W-1:0];
        timer  <= '0;
      end else if (timer_run) begin
        timer <= timer + TW'(1);
      end
      if (capture) begin
        res_d   <= fpu_d;
        res_err <= 1'b0;
      end else if (abort) begin
        res_d   <= QNAN;
        res_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb/tb_fpu_cmd_sequencer.sv - directed bench for fpu_cmd_sequencer with a behavioural FPU stub
module tb_fpu_cmd_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             res_valid, res_ready;
  logic [31:0]      res_d;
  logic [TAG_W-1:0] res_tag;
  logic             res_err, busy;
  logic [31:0]      fpu_a, fpu_b, fpu_d;
  logic [1:0]       fpu_op;
  logic             fpu_go, fpu_reset, fpu_done;

  fpu_cmd_sequencer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_d(res_d),
    .res_tag(res_tag), .res_err(res_err), .busy(busy),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_go(fpu_go),
    .fpu_reset(fpu_reset), .fpu_d(fpu_d), .fpu_done(fpu_done)
  );

  always #5 clk = ~clk;

  // Directed vectors: ADD 1+2, MULT 2*3, DIV 6/2, SUB 3-1.
  logic [1:0]  vop [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
  logic [31:0] va  [4] = '{32'h3F800000, 32'h40000000, 32'h40C00000, 32'h40400000};
  logic [31:0] vb  [4] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h3F800000};
  logic [31:0] vr  [4] = '{32'h40400000, 32'h40C00000, 32'h40400000, 32'h40000000};

  int total = 0;
  int bad   = 0;
  int mode  = 0;   // 0 normal, 1 hung, 2 stale done
  int go_count = 0;
  int rst_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] fpu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++)
      if (op == vop[i] && a == va[i] && b == vb[i]) return vr[i];
    return 32'hFFFF0000;
  endfunction

  // FPU stub: reacts on the falling edge so the DUT sees stable inputs at posedge.
  logic [31:0] pend;
  int k;
  bit active = 0;
  always @(negedge clk) begin
    if (fpu_go) go_count++;
    if (fpu_reset && !reset) rst_count++;
    if (fpu_reset) begin
      fpu_done = 1'b0;
      active = 0;
    end else if (fpu_go) begin
      pend = fpu_model(fpu_op, fpu_a, fpu_b);
      k = 0;
      active = (mode != 1);
      if (mode == 2) begin
        fpu_done = 1'b1;
        fpu_d = 32'hDEADBEEF;
      end else begin
        fpu_done = 1'b0;
      end
    end else if (active) begin
      k++;
      if (mode == 0) begin
        if (k == 3) begin fpu_done = 1'b1; fpu_d = pend; active = 0; end
      end else begin
        if (k == 3) fpu_done = 1'b0;
        else if (k == 5) begin fpu_done = 1'b1; fpu_d = 32'h12345678; active = 0; end
      end
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    check("push_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic take_result(output logic [31:0] d, output logic [3:0] tg, output logic e);
    int n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    check("res_wait", 32'(res_valid), 32'd1);
    d = res_d; tg = res_tag; e = res_err;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic [3:0]  tg;
  logic        e;
  int g0, n, seen;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    fpu_done = 1'b1; fpu_d = '0;
    repeat (3) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_go", 32'(fpu_go), 0);
    check("rst_fpu_reset", 32'(fpu_reset), 1);
    check("rst_res_d", res_d, 0);
    check("rst_fpu_a", fpu_a, 0);
    reset = 1'b0;
    @(negedge clk);
    check("fpu_reset_off", 32'(fpu_reset), 0);

    // 1: ADD with go latency and single-cycle go
    g0 = go_count;
    push_cmd(vop[0], va[0], vb[0], 4'd5);
    check("t1_go_pre", 32'(fpu_go), 0);
    @(negedge clk);
    check("t1_go", 32'(fpu_go), 1);
    check("t1_fpu_a", fpu_a, va[0]);
    check("t1_fpu_op", 32'(fpu_op), 32'd2);
    @(negedge clk);
    check("t1_go_post", 32'(fpu_go), 0);
    take_result(d, tg, e);
    check("t1_d", d, vr[0]);
    check("t1_tag", 32'(tg), 5);
    check("t1_err", 32'(e), 0);
    check("t1_go_once", 32'(go_count - g0), 1);

    // 2: MULT, DIV, SUB
    for (int i = 1; i < 4; i++) begin
      push_cmd(vop[i], va[i], vb[i], 4'(i + 8));
      take_result(d, tg, e);
      check("t2_d", d, vr[i]);
      check("t2_tag", 32'(tg), 32'(i + 8));
    end

    // 3: hold one result, fill the FIFO, then drain in order
    push_cmd(vop[0], va[0], vb[0], 4'd15);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    check("t3_hold", 32'(res_valid), 1);
    for (int i = 0; i < 4; i++) begin
      cmd_op = vop[i]; cmd_a = va[i]; cmd_b = vb[i]; cmd_tag = 4'(i); cmd_valid = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("t3_full", 32'(cmd_ready), 0);
    g0 = go_count;
    repeat (20) @(negedge clk);
    check("t3_no_go", 32'(go_count - g0), 0);
    take_result(d, tg, e);
    check("t3_tag_first", 32'(tg), 15);
    for (int i = 0; i < 4; i++) begin
      take_result(d, tg, e);
      check("t3_tag", 32'(tg), 32'(i));
      check("t3_d", d, vr[i]);
    end

    // 4: hung FPU -> timeout, then recovery
    mode = 1;
    rst_count = 0;
    push_cmd(vop[0], va[0], vb[0], 4'd7);
    n = 0;
    while (!fpu_go && n < 20) begin @(negedge clk); n++; end
    check("t4_go", 32'(fpu_go), 1);
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    check("t4_latency", 32'(n), 65);
    check("t4_fpu_reset", 32'(fpu_reset), 1);
    take_result(d, tg, e);
    check("t4_d", d, 32'h7FFFFFFF);
    check("t4_err", 32'(e), 1);
    check("t4_tag", 32'(tg), 7);
    check("t4_rst_pulse", 32'(rst_count), 1);
    mode = 0;
    push_cmd(vop[3], va[3], vb[3], 4'd2);
    take_result(d, tg, e);
    check("t4_recover_d", d, vr[3]);
    check("t4_recover_err", 32'(e), 0);

    // 5: stale done must not be captured
    mode = 2;
    push_cmd(vop[2], va[2], vb[2], 4'd9);
    take_result(d, tg, e);
    check("t5_d", d, 32'h12345678);
    check("t5_err", 32'(e), 0);
    check("t5_tag", 32'(tg), 9);

    // 6: reset while waiting with two queued commands
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      cmd_op = vop[i]; cmd_a = va[i]; cmd_b = vb[i]; cmd_tag = 4'(i); cmd_valid = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_res_valid", 32'(res_valid), 0);
    check("t6_cmd_ready", 32'(cmd_ready), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_go", 32'(fpu_go), 0);
    check("t6_fpu_reset", 32'(fpu_reset), 1);
    reset = 1'b0;
    mode = 0;
    g0 = go_count;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("t6_no_result", 32'(seen), 0);
    check("t6_no_go", 32'(go_count - g0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_cmd_sequencer.md
Name: fpu_cmd_sequencer

Overview:
Initiator side of the single-precision FPU's go/done interface.
- Accepts operation commands (op, a, b, tag) on a valid/ready stream and buffers them in a small in-order FIFO.
- Issues one command at a time to the FPU, waits for a genuine completion, and returns the result with its tag on a valid/ready result stream.
- Guards against a hung FPU with a timeout that yields qNaN plus an error flag, and pulses the FPU's reset to recover it.

Parameters:
DEPTH, 4, command FIFO entries; power of two, at least 2.
TAG_W, 4, width of the command/result tag.
TIMEOUT, 64, max cycles from go to done before abort; must exceed the FPU's worst-case normalise time.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept; equals !full.
cmd_op  in  2  0=mult, 1=div, 2=add, 3=sub.
cmd_a  in  32  operand A, IEEE754 single.
cmd_b  in  32  operand B, IEEE754 single.
cmd_tag  in  TAG_W  user tag, returned with result.
res_valid  out  1  result held.
res_ready  in  1  consumer takes result.
res_d  out  32  result word.
res_tag  out  TAG_W  tag of completed command.
res_err  out  1  1 = timeout abort; res_d is qNaN.
busy  out  1  high when not IDLE or FIFO non-empty.
fpu_a  out  32  to FPU a.
fpu_b  out  32  to FPU b.
fpu_op  out  2  to FPU op.
fpu_go  out  1  to FPU go; single-cycle pulse.
fpu_reset  out  1  to FPU reset.
fpu_d  in  32  FPU result.
fpu_done  in  1  FPU done.

Behaviour:
Reset:
- While reset=1, all of the following hold: FIFO emptied; state IDLE; res_valid=0; res_err=0; res_d=0; res_tag=0; fpu_go=0; fpu_a/fpu_b/fpu_op=0; timer=0; fpu_reset=1.
- Reset mid-operation abandons the in-flight command with no result.

FIFO:
- Push on cmd_valid&&cmd_ready; pop only in IDLE on issue.
- No fall-through: an entry pushed at edge E is poppable at E+1.
- When full, cmd_ready=0 even if a pop occurs the same cycle (no bypass).
- Pointers wrap modulo DEPTH; occupancy count is clog2(DEPTH)+1 bits.

States: IDLE, ISSUE, ARM, WAIT, HOLD.
- IDLE: if FIFO non-empty, load head into fpu_a/fpu_b/fpu_op and the tag register, pop, clear timer, go to ISSUE.
- ISSUE: fpu_go=1 for exactly this cycle; go to ARM.
- ARM: wait for fpu_done==0, which proves the FPU accepted go and cleared its stale done; then go to WAIT.
- WAIT: on fpu_done==1, capture fpu_d into res_d, set res_err=0, res_valid=1, go to HOLD.
- HOLD: res_valid=1. On res_ready, clear res_valid and go to IDLE; the next issue occurs no earlier than the following cycle.
- fpu_a/fpu_b/fpu_op stay stable from IDLE load until WAIT exits, because the FPU samples op after go.
- res_d, res_tag and res_err stay stable while res_valid=1.

Timeout:
- Timer increments every cycle in ARM and WAIT.
- When timer==TIMEOUT-1 with no completion: res_d=32'h7FFFFFFF, res_err=1, res_valid=1, fpu_reset=1 for one cycle, go to HOLD.
- If done and timeout occur in the same cycle, done wins.
- fpu_reset is otherwise 0 outside reset.

Latency:
- Push at E0 → pop at E1 → fpu_go high during cycle E1..E2.
- res_valid rises one cycle after fpu_done is first seen high in WAIT.
- Commands complete strictly in push order; at most one is outstanding at the FPU.

Decomposition:
- Shared package fpu_pkg holds:
  - op encodings OP_MULT/OP_DIV/OP_ADD/OP_SUB;
  - field positions SIGN_BIT, EXP_MSB/LSB, FRAC_MSB/LSB;
  - constants PZERO, NZERO, PINF, NINF, QNAN=32'h7FFFFFFF.
- State enum lives locally.
- One sub-module: fpu_cmd_fifo, a synchronous FIFO parameterised by DEPTH and entry width 66+TAG_W.

Test Plan:
1. ADD a=3F800000 b=40000000 tag=5 with the real FPU → res_d=40400000, res_tag=5, res_err=0; fpu_go high exactly one cycle.
2. MULT 40000000×40400000 → 40C00000; DIV 40C00000/40000000 → 40400000; SUB 40400000−3F800000 → 40000000.
3. Push 4 commands back-to-back (tags 0..3):
   - cmd_ready falls after the 4th push.
   - With res_ready=0, no second fpu_go occurs.
   - After releasing res_ready, results return in tag order 0,1,2,3.
4. FPU stub holds done=0 forever, TIMEOUT=64 → res_d=7FFFFFFF and res_err=1, with fpu_reset pulsed for one cycle, 64 cycles after fpu_go; the next command then completes normally.
5. FPU stub keeps done=1 for 3 cycles after go, then drops it for 2 cycles, then raises it with d=12345678 → no capture of the stale done; res_d=12345678.
6. Assert reset in WAIT with 2 entries queued → next cycle res_valid=0, cmd_ready=1, busy=0, fpu_go=0, fpu_reset=1; no result emitted after reset is released.
